// File: rtl/wb_reg_writer.sv
// Writeback stage: bypass broadcast of completed results plus an in-order
// write buffer draining into the physical register file through a granted port.
module wb_reg_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 7,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              recoverFlag_i,
    input  logic              wbValid_i,
    input  logic              wbDestValid_i,
    input  logic [TAG_W-1:0]  wbPhyDest_i,
    input  logic [DATA_W-1:0] wbData_i,
    output logic              wbReady_o,
    output logic              bypassValid_o,
    output logic [TAG_W-1:0]  bypassTag_o,
    output logic [DATA_W-1:0] bypassData_o,
    output logic              rfWrEn_o,
    output logic [TAG_W-1:0]  rfWrAddr_o,
    output logic [DATA_W-1:0] rfWrData_o,
    input  logic              rfWrGnt_i,
    input  logic [TAG_W-1:0]  lookupTag_i,
    output logic              lookupHit_o,
    output logic [DATA_W-1:0] lookupData_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } wbEntry_t;

    logic          s1Valid;
    wbEntry_t      s1Q;
    wbEntry_t      bufQ [FIFO_DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          acc;
    logic          push;
    logic          pop;
    logic [PW-1:0] idx;

    // Ready looks only at registered state, so a pop cannot raise it early.
    assign occupancy = {1'b0, count} + (CW+1)'(s1Valid);
    assign wbReady_o = !recoverFlag_i
                     && (occupancy < (CW+1)'(FIFO_DEPTH));

    assign acc  = wbValid_i && wbDestValid_i && wbReady_o;
    assign push = s1Valid;
    assign pop  = rfWrEn_o && rfWrGnt_i;

    assign bypassValid_o = s1Valid;
    assign bypassTag_o   = s1Valid ? s1Q.tag  : '0;
    assign bypassData_o  = s1Valid ? s1Q.data : '0;

    assign rfWrEn_o   = (count != '0);
    assign rfWrAddr_o = rfWrEn_o ? bufQ[headPtr].tag  : '0;
    assign rfWrData_o = rfWrEn_o ? bufQ[headPtr].data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid <= 1'b0;
            s1Q     <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) bufQ[i] <= '0;
        end else if (recoverFlag_i) begin
            s1Valid <= 1'b0;
            s1Q     <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) bufQ[i] <= '0;
        end else begin
            s1Valid <= acc;
            if (acc) begin
                s1Q.tag  <= wbPhyDest_i;
                s1Q.data <= wbData_i;
            end
            if (push) begin
                bufQ[tailPtr] <= s1Q;
                tailPtr       <= tailPtr + 1'b1;
            end
            if (pop) headPtr <= headPtr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so later matches override; S1 is youngest.
    always_comb begin
        lookupHit_o  = 1'b0;
        lookupData_o = '0;
        idx          = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = headPtr + PW'(i);
            if ((CW'(i) < count) && (bufQ[idx].tag == lookupTag_i)) begin
                lookupHit_o  = 1'b1;
                lookupData_o = bufQ[idx].data;
            end
        end
        if (s1Valid && (s1Q.tag == lookupTag_i)) begin
            lookupHit_o  = 1'b1;
            lookupData_o = s1Q.data;
        end
    end

endmodule
